// File: rtl/alu_pkg.sv
// Shared definitions for the alu and its round-robin front end: default widths,
// opcode encodings, the arbiter FSM state type and a small index-width helper.
package alu_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int SELW_DEF  = 3;

  localparam logic [SELW_DEF-1:0] OP_ADD = 3'b000;
  localparam logic [SELW_DEF-1:0] OP_SUB = 3'b001;
  localparam logic [SELW_DEF-1:0] OP_AND = 3'b010;
  localparam logic [SELW_DEF-1:0] OP_OR  = 3'b011;
  localparam logic [SELW_DEF-1:0] OP_XOR = 3'b100;
  localparam logic [SELW_DEF-1:0] OP_NOT = 3'b101;
  localparam logic [SELW_DEF-1:0] OP_SHL = 3'b110;
  localparam logic [SELW_DEF-1:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // A single requester still needs a one-bit index register.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational WIDTH-bit alu; carries, borrows and shifted-out bits are discarded.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SELW  = SELW_DEF
) (
  input  logic [SELW-1:0]  sel,
  input  logic [WIDTH-1:0] IN0,
  input  logic [WIDTH-1:0] IN1,
  output logic [WIDTH-1:0] OUT
);

  always_comb begin
    OUT = '0;
    case (sel)
      OP_ADD:  OUT = IN0 + IN1;
      OP_SUB:  OUT = IN0 - IN1;
      OP_AND:  OUT = IN0 & IN1;
      OP_OR:   OUT = IN0 | IN1;
      OP_XOR:  OUT = IN0 ^ IN1;
      OP_NOT:  OUT = ~IN0;
      OP_SHL:  OUT = IN0 << 1;
      OP_SHR:  OUT = IN0 >> 1;
      default: OUT = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one alu between NREQ requesters (IDLE -> EXEC -> RESP).
// Define ALU_ZERO_FLAG_EN to add the registered rsp_zero output.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SELW  = SELW_DEF,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*SELW-1:0]  req_sel,
  input  logic [NREQ*WIDTH-1:0] req_in0,
  input  logic [NREQ*WIDTH-1:0] req_in1,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic                  rsp_zero
`endif
);

  localparam int              IDXW     = idxWidth(NREQ);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

  state_t            state_q;
  logic [IDXW-1:0]   rrLast_q;
  logic [SELW-1:0]   opSel_q;
  logic [WIDTH-1:0]  opA_q;
  logic [WIDTH-1:0]  opB_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   rspValid_q;
  logic [WIDTH-1:0]  rspData_q;
`ifdef ALU_ZERO_FLAG_EN
  logic              rspZero_q;
`endif

  logic [SELW-1:0]   selArr [NREQ];
  logic [WIDTH-1:0]  in0Arr [NREQ];
  logic [WIDTH-1:0]  in1Arr [NREQ];

  logic              pickValid;
  logic [IDXW-1:0]   pickIdx;
  logic [IDXW-1:0]   cand;
  logic [NREQ-1:0]   pickGnt;
  logic [WIDTH-1:0]  aluOut;

  for (genvar i = 0; i < NREQ; i++) begin : gUnpack
    assign selArr[i] = req_sel[i*SELW +: SELW];
    assign in0Arr[i] = req_in0[i*WIDTH +: WIDTH];
    assign in1Arr[i] = req_in1[i*WIDTH +: WIDTH];
  end

  // Walk from the farthest candidate down to rrLast+1 so the nearest set bit wins.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    cand      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDXW'((int'(rrLast_q) + k) % NREQ);
      if (req[cand]) begin
        pickValid = 1'b1;
        pickIdx   = cand;
      end
    end
  end

  assign pickGnt = NREQ'(1) << pickIdx;

  alu #(
    .WIDTH (WIDTH),
    .SELW  (SELW)
  ) uAlu (
    .sel (opSel_q),
    .IN0 (opA_q),
    .IN1 (opB_q),
    .OUT (aluOut)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rrLast_q   <= LAST_IDX;
      opSel_q    <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      gnt_q      <= '0;
      rspValid_q <= '0;
      rspData_q  <= '0;
`ifdef ALU_ZERO_FLAG_EN
      rspZero_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          rspValid_q <= '0;
          if (pickValid) begin
            opSel_q  <= selArr[pickIdx];
            opA_q    <= in0Arr[pickIdx];
            opB_q    <= in1Arr[pickIdx];
            gnt_q    <= pickGnt;
            rrLast_q <= pickIdx;
            state_q  <= EXEC;
          end
        end
        // The grant vector doubles as the response target, so no index is stored.
        EXEC: begin
          rspData_q  <= aluOut;
          rspValid_q <= gnt_q;
          gnt_q      <= '0;
`ifdef ALU_ZERO_FLAG_EN
          rspZero_q  <= (aluOut == '0);
`endif
          state_q    <= RESP;
        end
        RESP: begin
          rspValid_q <= '0;
          state_q    <= IDLE;
        end
        default: begin
          gnt_q      <= '0;
          rspValid_q <= '0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rspValid_q;
  assign rsp_data  = rspData_q;
  assign busy      = (state_q != IDLE);
`ifdef ALU_ZERO_FLAG_EN
  assign rsp_zero  = rspZero_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: opcode table, simultaneous/fair arbitration and
// reset during EXEC; rsp_zero is also checked when ALU_ZERO_FLAG_EN is defined.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int WIDTH = 4;
  localparam int SELW  = 3;
  localparam int NREQ  = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*SELW-1:0]  reqSel;
  logic [NREQ*WIDTH-1:0] reqIn0;
  logic [NREQ*WIDTH-1:0] reqIn1;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rspValid;
  logic [WIDTH-1:0]      rspData;
  logic                  busy;
`ifdef ALU_ZERO_FLAG_EN
  logic                  rspZero;
`endif

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;

  typedef struct {
    int         who;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] expData;
  } vec_t;

  vec_t vecs [12];

  alu_arbiter #(
    .WIDTH (WIDTH),
    .SELW  (SELW),
    .NREQ  (NREQ)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_sel   (reqSel),
    .req_in0   (reqIn0),
    .req_in1   (reqIn1),
    .gnt       (gnt),
    .rsp_valid (rspValid),
    .rsp_data  (rspData),
    .busy      (busy)
`ifdef ALU_ZERO_FLAG_EN
    ,
    .rsp_zero  (rspZero)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic loadOperands(input int who, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    reqSel[who*SELW +: SELW]  = op;
    reqIn0[who*WIDTH +: WIDTH] = a;
    reqIn1[who*WIDTH +: WIDTH] = b;
  endtask

  // Called on a falling edge; runs one isolated request through grant, response and idle.
  task automatic applyStimulus(input int idx, input vec_t v);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << v.who;
    loadOperands(v.who, v.op, v.a, v.b);
    req = oh;
    @(negedge clk);
    checkOutput($sformatf("v%0d gnt", idx), 32'(gnt), 32'(oh));
    checkOutput($sformatf("v%0d busy exec", idx), 32'(busy), 32'd1);
    checkOutput($sformatf("v%0d rsp_valid exec", idx), 32'(rspValid), 32'd0);
    req = '0;
    @(negedge clk);
    checkOutput($sformatf("v%0d rsp_valid", idx), 32'(rspValid), 32'(oh));
    checkOutput($sformatf("v%0d rsp_data", idx), 32'(rspData), 32'(v.expData));
    checkOutput($sformatf("v%0d gnt resp", idx), 32'(gnt), 32'd0);
    checkOutput($sformatf("v%0d busy resp", idx), 32'(busy), 32'd1);
`ifdef ALU_ZERO_FLAG_EN
    checkOutput($sformatf("v%0d rsp_zero", idx), 32'(rspZero), 32'(v.expData == 4'h0));
`endif
    @(negedge clk);
    checkOutput($sformatf("v%0d busy idle", idx), 32'(busy), 32'd0);
    checkOutput($sformatf("v%0d rsp_valid idle", idx), 32'(rspValid), 32'd0);
    checkOutput($sformatf("v%0d rsp_data hold", idx), 32'(rspData), 32'(v.expData));
  endtask

  task automatic waitGrant(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (gnt != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic            ok;
    logic            sawRsp;
    int              lastGrant;
    logic [NREQ-1:0] expGnt;

    reset  = 1'b1;
    req    = '0;
    reqSel = '0;
    reqIn0 = '0;
    reqIn1 = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset gnt", 32'(gnt), 32'd0);
    checkOutput("reset rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("reset rsp_data", 32'(rspData), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    vecs[0]  = '{0, OP_ADD, 4'h5, 4'h3, 4'h8};
    vecs[1]  = '{1, OP_SUB, 4'h5, 4'h3, 4'h2};
    vecs[2]  = '{0, OP_AND, 4'h5, 4'h3, 4'h1};
    vecs[3]  = '{1, OP_OR,  4'h5, 4'h3, 4'h7};
    vecs[4]  = '{0, OP_XOR, 4'h5, 4'h3, 4'h6};
    vecs[5]  = '{1, OP_NOT, 4'h5, 4'h3, 4'hA};
    vecs[6]  = '{0, OP_SHL, 4'h5, 4'h3, 4'hA};
    vecs[7]  = '{1, OP_SHR, 4'h5, 4'h3, 4'h2};
    vecs[8]  = '{0, OP_ADD, 4'hF, 4'h1, 4'h0};
    vecs[9]  = '{1, OP_SUB, 4'h0, 4'h1, 4'hF};
    vecs[10] = '{0, OP_SHL, 4'h9, 4'h0, 4'h2};
    vecs[11] = '{1, OP_XOR, 4'hA, 4'hA, 4'h0};

    for (int i = 0; i < 12; i++) applyStimulus(i, vecs[i]);

    // Fresh reset puts rr_last at NREQ-1, so requester 0 must win the first tie.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    loadOperands(0, OP_SUB, 4'h5, 4'h3);
    loadOperands(1, OP_AND, 4'h5, 4'h3);
    req = 2'b11;
    lastGrant = 0;
    for (int k = 0; k < 6; k++) begin
      expGnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      waitGrant(ok);
      checkOutput($sformatf("fair%0d grant seen", k), 32'(ok), 32'd1);
      if (!ok) break;
      checkOutput($sformatf("fair%0d gnt", k), 32'(gnt), 32'(expGnt));
      if (k > 0) checkOutput($sformatf("fair%0d spacing", k), 32'(cycleCount - lastGrant), 32'd3);
      lastGrant = cycleCount;
      @(negedge clk);
      checkOutput($sformatf("fair%0d rsp_valid", k), 32'(rspValid), 32'(expGnt));
      checkOutput($sformatf("fair%0d rsp_data", k), 32'(rspData), (k % 2 == 0) ? 32'h2 : 32'h1);
      if (k == 5) req = '0;
    end
    req = '0;
    repeat (2) @(negedge clk);

    loadOperands(0, OP_ADD, 4'h1, 4'h1);
    req = 2'b01;
    @(negedge clk);
    checkOutput("rst-exec gnt before", 32'(gnt), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("rst-exec gnt", 32'(gnt), 32'd0);
    checkOutput("rst-exec rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("rst-exec busy", 32'(busy), 32'd0);
    checkOutput("rst-exec rsp_data", 32'(rspData), 32'd0);
    req = '0;
    @(negedge clk);
    reset = 1'b0;
    sawRsp = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (rspValid != '0 || gnt != '0) sawRsp = 1'b1;
    end
    checkOutput("rst-exec no late rsp", 32'(sawRsp), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
